debounce: RTL and testbench
===========================

Name: debounce

Overview:
Filters a noisy, asynchronous single-bit input, such as a push-button or switch, into a clean level on the system clock domain.
- Input is synchronised first.
- The output changes only after the synchronised input holds a new level for STABLE_CYCLES consecutive clocks.
- One-cycle edge pulses are also provided for downstream control logic.
- Sits between board-level button pins and game/UI control FSMs.

Parameters:
- STABLE_CYCLES, 16: consecutive clocks the synchronised input must hold a new level before the output follows; legal range >= 2.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser; legal range >= 2.
- RESET_LEVEL, 1'b0: value of debounced_signal and of every synchroniser stage during and after reset.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- noisy_signal  input  1  raw asynchronous input, may bounce
- debounced_signal  output  1  filtered level, registered
- rise_pulse  output  1  one-cycle high when debounced_signal goes 0->1
- fall_pulse  output  1  one-cycle high when debounced_signal goes 1->0

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-to-clk release):
  - all synchroniser stages = RESET_LEVEL
  - debounced_signal = RESET_LEVEL
  - counter = 0
  - rise_pulse = 0, fall_pulse = 0
- Synchroniser: SYNC_STAGES-deep shift chain; sync_out is the last stage. No logic between stages.
- Counter: width $clog2(STABLE_CYCLES+1), unsigned, saturating (never wraps).
- Each rising clk edge, when sync_out == debounced_signal: counter <= 0, output held.
- When sync_out != debounced_signal and counter < STABLE_CYCLES-1: counter <= counter+1.
- When sync_out != debounced_signal and counter == STABLE_CYCLES-1: debounced_signal <= sync_out, counter <= 0.
- Any return of sync_out to the current output level before the threshold restarts the count from 0. No partial credit is kept.
- Latency: a clean input step appears on debounced_signal exactly SYNC_STAGES + STABLE_CYCLES rising edges after the first edge sampling the new level, with +-1 cycle metastability uncertainty at the first stage.
- Minimum accepted pulse width at the input: STABLE_CYCLES clocks. Shorter pulses are fully rejected and produce no output change or edge pulse.
- rise_pulse and fall_pulse:
  - registered; asserted in the same cycle debounced_signal takes its new value
  - high for exactly one clk
  - never both high in one cycle
- Reset asserted mid-count discards the count; the output returns to RESET_LEVEL immediately, with no edge pulse generated.
- Input held constant at RESET_LEVEL after reset: outputs never toggle.

Decomposition:
- Package debounce_pkg:
  - default constants DEBOUNCE_STABLE_CYCLES_DEF = 16, DEBOUNCE_SYNC_STAGES_DEF = 2
  - localparam function for counter width
- Sub-module sync_chain: parameterised SYNC_STAGES-deep, RESET_LEVEL-initialised bit synchroniser. It is instantiated once and reusable elsewhere.
- Counter, compare and edge-pulse logic live in debounce itself.

Test Plan (clk period 10 ns, STABLE_CYCLES=4, SYNC_STAGES=2):
1. Reset held 100 ns with noisy_signal=1, then released.
   - Required: debounced_signal=0 and both pulses 0 during reset.
   - Required: debounced_signal rises 6 clocks after release, with rise_pulse high for 1 clock.
2. Glitch train 1 for 20 ns, 0 for 20 ns, 1 for 20 ns, then 0.
   - Required: debounced_signal stays 0 and rise_pulse never asserts.
3. Clean step 0->1 held 200 ns.
   - Required: debounced_signal=1 exactly 6 edges after the first sampling edge.
   - Required: rise_pulse=1 that cycle only; fall_pulse=0 throughout.
4. From debounced=1, input low for 3 clocks, high 1 clock, low 10 clocks.
   - Required: no change on the first dip.
   - Required: fall to 0 occurs 6 clocks after the final low begins; fall_pulse for 1 clock.
5. Input high for 3 clocks, then rst_n pulsed low for 1 ns mid-count.
   - Required: outputs immediately 0 and counter restarts.
   - Required: output follows only after a full 4-cycle stable window post-reset.
6. Randomised bounce (1-3 clock toggles) for 500 ns, then stable level.
   - Required: exactly one output transition and one matching edge pulse, per scoreboard model.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and counter sizing for the debounce filter
package debounce_pkg;

  localparam int DEBOUNCE_STABLE_CYCLES_DEF = 16;
  localparam int DEBOUNCE_SYNC_STAGES_DEF   = 2;

  // Wide enough to hold STABLE_CYCLES itself, so the compare value always fits.
  function automatic int debounce_cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-stage single-bit synchroniser with a configurable reset level
module sync_chain
  import debounce_pkg::*;
#(
  parameter int   STAGES      = DEBOUNCE_SYNC_STAGES_DEF,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic [STAGES-1:0] chain;

  // Pure shift chain: nothing may sit between stages or metastability escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_LEVEL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_bit};
    end
  end

  assign sync_bit = chain[STAGES-1];

endmodule

// File: rtl/debounce.sv
// rtl/debounce.sv - synchronise and debounce a bouncing input, with registered edge pulses
module debounce
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES_DEF,
  parameter int   SYNC_STAGES   = DEBOUNCE_SYNC_STAGES_DEF,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy_signal,
  output logic debounced_signal,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int            CW   = debounce_cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          sync_out;
  logic [CW-1:0] count;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_bit (noisy_signal),
    .sync_bit  (sync_out)
  );

  // Any sample matching the current output wipes the count: no partial credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debounced_signal <= RESET_LEVEL;
      count            <= '0;
      rise_pulse       <= 1'b0;
      fall_pulse       <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (sync_out == debounced_signal) begin
        count <= '0;
      end else if (count < LAST) begin
        count <= count + 1'b1;
      end else begin
        debounced_signal <= sync_out;
        count            <= '0;
        rise_pulse       <= sync_out;
        fall_pulse       <= ~sync_out;
      end
    end
  end

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - scoreboard bench for debounce with STABLE_CYCLES=4, SYNC_STAGES=2
`timescale 1ns/100ps
module tb_debounce;

  logic clk = 1'b0;
  logic rst_n;
  logic noisy_signal;
  logic debounced_signal;
  logic rise_pulse;
  logic fall_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit rise;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  logic prev_level = 1'b0;
  bit   rst_event  = 1'b0;

  int bounce[24] = '{3, 1, 2, 3, 1, 1, 3, 2, 2, 1, 1, 3,
                     3, 2, 1, 2, 3, 1, 2, 3, 1, 1, 2, 3};

  debounce #(
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .noisy_signal     (noisy_signal),
    .debounced_signal (debounced_signal),
    .rise_pulse       (rise_pulse),
    .fall_pulse       (fall_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst_n) rst_event = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit rise, input int at);
    exp_t n;
    n.rise = rise;
    n.cyc  = at;
    q.push_back(n);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every edge pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rise_pulse || fall_pulse) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        check("pulse_exclusive", int'(rise_pulse & fall_pulse), 0);
        check("edge_kind", int'(rise_pulse), int'(e.rise));
        check("edge_cycle", cyc, e.cyc);
        check("edge_level", int'(debounced_signal), int'(e.rise));
      end
    end else if (debounced_signal != prev_level && !rst_event) begin
      check("silent_change", int'(debounced_signal), int'(prev_level));
    end
    prev_level = debounced_signal;
    rst_event  = 1'b0;
  end

  initial begin
    rst_n        = 1'b0;
    noisy_signal = 1'b1;

    // 1: reset held 100 ns with input high, then released
    step(5);
    check("reset_level", int'(debounced_signal), 0);
    check("reset_rise", int'(rise_pulse), 0);
    check("reset_fall", int'(fall_pulse), 0);
    step(5);
    rst_n = 1'b1;
    push(1'b1, cyc + 6);
    step(5);
    check("post_reset_still_low", int'(debounced_signal), 0);
    step(1);
    check("post_reset_rise", int'(debounced_signal), 1);
    step(3);

    noisy_signal = 1'b0;
    push(1'b0, cyc + 6);
    step(10);

    // 2: glitch train, every high run shorter than the window
    noisy_signal = 1'b1;
    step(2);
    noisy_signal = 1'b0;
    step(2);
    noisy_signal = 1'b1;
    step(2);
    noisy_signal = 1'b0;
    step(10);
    check("glitch_rejected", int'(debounced_signal), 0);

    // 3: clean step held 200 ns
    noisy_signal = 1'b1;
    push(1'b1, cyc + 6);
    step(5);
    check("step_edge5", int'(debounced_signal), 0);
    step(1);
    check("step_edge6", int'(debounced_signal), 1);
    check("step_rise_pulse", int'(rise_pulse), 1);
    step(1);
    check("step_rise_once", int'(rise_pulse), 0);
    step(13);

    // 4: dip of 3 clocks rejected, final low accepted
    noisy_signal = 1'b0;
    step(3);
    noisy_signal = 1'b1;
    step(1);
    noisy_signal = 1'b0;
    push(1'b0, cyc + 6);
    step(5);
    check("dip_rejected", int'(debounced_signal), 1);
    step(1);
    check("fall_after_dip", int'(debounced_signal), 0);
    check("fall_pulse_seen", int'(fall_pulse), 1);
    step(8);

    // 5: reset pulse mid-count restarts synchroniser and counter
    noisy_signal = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #0.5;
    check("midcount_reset_level", int'(debounced_signal), 0);
    check("midcount_reset_rise", int'(rise_pulse), 0);
    #0.5 rst_n = 1'b1;
    push(1'b1, cyc + 6);
    step(5);
    check("restart_full_window", int'(debounced_signal), 0);
    step(1);
    check("restart_rise", int'(debounced_signal), 1);
    step(4);

    // 5b: reset while high drops output with no fall pulse
    noisy_signal = 1'b0;
    step(3);
    #2 rst_n = 1'b0;
    #0.5;
    check("reset_from_high_level", int'(debounced_signal), 0);
    check("reset_from_high_fall", int'(fall_pulse), 0);
    #0.5 rst_n = 1'b1;
    step(10);
    check("idle_at_reset_level", int'(debounced_signal), 0);

    // 6: bounce of 1-3 clock toggles, then a stable high
    for (int i = 0; i < 24; i++) begin
      noisy_signal = (i % 2 == 0);
      step(bounce[i]);
    end
    check("bounce_rejected", int'(debounced_signal), 0);
    noisy_signal = 1'b1;
    push(1'b1, cyc + 6);
    step(20);

    check("queue_drained", q.size(), 0);
    check("final_level", int'(debounced_signal), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
